button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
// - Consumes the debounced button bus and turns levels into discrete events: press, release, long-press and (optional) auto-repeat.
// - Per-bit pulses drive local logic directly; a serialised event stream with valid/ready feeds the control/register block of the video synth.
// - Hold and repeat timing counts a slow tick strobe, so counters stay narrow.
// PARAMETERS
// - NUM_BITS      8   buttons on the debounced bus
// - HOLD_TICKS    500 ticks held before long-press fires (>=1)
// - REPEAT_TICKS  100 ticks between auto-repeat events (>=1)
// - CNT_W         derived: $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1), localparam
// PORTS
// - clk          in   1                  system clock
// - reset        in   1                  synchronous, active-low reset
// - level        in   NUM_BITS           debounced button levels, 1 = pressed
// - tick         in   1                  1-cycle timing strobe (e.g. 1 kHz)
// - press        out  NUM_BITS           1-cycle pulse on rising level
// - release      out  NUM_BITS           1-cycle pulse on falling level
// - long_press   out  NUM_BITS           1-cycle pulse when hold threshold reached
// - ev_valid     out  1                  event available
// - ev_ready     in   1                  consumer accepts when ev_valid & ev_ready
// - ev_idx       out  $clog2(NUM_BITS)   button index of event
// - ev_type      out  2                  EV_PRESS/EV_RELEASE/EV_LONG/EV_REPEAT
// - ev_overflow  out  1                  sticky: event lost while still pending
// BEHAVIOUR
// - reset==0 at a clk edge: all outputs 0, per-bit state IDLE, prev-level regs 0, pending flags 0, counters 0, ev_overflow 0.
// - Buttons held across reset deassertion report a press 1 cycle later (prev is 0).
// - Latency: level edge sampled at cycle n -> press/release pulse at n+1 -> ev_valid at n+2 at the earliest.
// - Per-bit FSM: IDLE -rise-> PRESSED (cnt=0); PRESSED: cnt++ on tick; at tick with cnt==HOLD_TICKS-1 -> long_press pulse, HELD (cnt=0).
// - Fall from any non-IDLE state -> release pulse, IDLE, cnt=0. Fall and tick in same cycle: fall wins, no long_press.
// - HELD without repeat: waits for fall. Counter saturates, never wraps.
// - Each pulse sets pending[bit][type]. Arbiter: lowest index first; within a bit RELEASE > LONG > REPEAT > PRESS.
// - ev_valid/ev_idx/ev_type registered; held stable until handshake; pending bit cleared on handshake.
// - New event whose pending flag is already set (and not cleared this cycle): ev_overflow <= 1; event dropped. Only reset clears.
// - ev_valid may stay high indefinitely with ev_ready low; per-bit pulses unaffected by backpressure.
// CONFIGURATION
// - BUTTON_AUTOREPEAT_EN defined: HELD counts ticks; at tick with cnt==REPEAT_TICKS-1 emit EV_REPEAT (pending + press pulse), cnt=0, stay HELD.
// - Undefined: no repeat logic, EV_REPEAT never produced, HELD is terminal until release.
// STRUCTURE
// - Package button_event_pkg: EV_PRESS=2'd0, EV_RELEASE=2'd1, EV_LONG=2'd2, EV_REPEAT=2'd3; channel state encodings IDLE/PRESSED/HELD.
// - Sub-module button_chan_fsm: one instance per bit (edge detect, FSM, counter, pulses); top holds pending flags and arbiter.
// TESTING (NUM_BITS=4, HOLD_TICKS=3, REPEAT_TICKS=2, tick every 4 clk, ev_ready=1 unless noted)
// - level[1] 0->1 at cycle 10 -> press[1] at 11; ev_valid, idx=1, type=PRESS at 12.
// - hold level[2] for 3 ticks -> exactly one long_press[2] on 3rd tick; release -> RELEASE event; no further LONG.
// - level[0] falls in same cycle as 3rd tick -> release[0] only, no long_press[0].
// - ev_ready=0, press/release bit 3 twice -> 2nd PRESS dropped, ev_overflow=1 and stays 1 after ready returns.
// - bits 0 and 3 rise same cycle -> events idx=0 then idx=3 on consecutive cycles.
// - BUTTON_AUTOREPEAT_EN: hold bit 1 for 9 ticks -> LONG at tick 3, REPEAT at ticks 5,7,9; undefined -> LONG only.
// - reset low mid-HELD with ev_valid=1 -> all outputs 0 next cycle; held button gives PRESS after reset release.

Source files
------------

// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : button_event_pkg
//  Description : Shared constants for the button event generator.
//                Event type codes carried on ev_type, the per-channel
//                state encodings, and a small helper for deriving the
//                timing counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_event_pkg;

    typedef logic [1:0] ev_type_t;

    // Event type codes (also used as the index into the per-bit pending vector)
    localparam ev_type_t EV_PRESS   = 2'd0;
    localparam ev_type_t EV_RELEASE = 2'd1;
    localparam ev_type_t EV_LONG    = 2'd2;
    localparam ev_type_t EV_REPEAT  = 2'd3;

    localparam int NUM_EV_TYPES = 4;

    // Per-channel state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_chan_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : button_chan_fsm
//  Description : One button channel. Detects edges on a debounced level,
//                runs the IDLE/PRESSED/HELD state machine, counts tick
//                strobes for long-press (and optional auto-repeat) timing,
//                and produces registered single-cycle pulses.
//  Ports       : clk, reset (sync, active-low), level, tick
//                press         - rise or auto-repeat pulse
//                release_pulse - falling-level pulse
//                long_press    - hold threshold reached
//                rise_ev       - rise only (feeds PRESS pending flag)
//                repeat_ev     - auto-repeat only (feeds REPEAT pending flag)
//  Config      : BUTTON_AUTOREPEAT_EN enables periodic repeat while HELD.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_chan_fsm
    import button_event_pkg::*;
#(
    parameter int HOLD_TICKS   = 500,
    parameter int CNT_W        = 9
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_TICKS = 100
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic tick,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic rise_ev,
    output logic repeat_ev
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_TICKS - 1);
`endif

    logic             r_prev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_rel;
    logic             r_long;
    logic             r_rep;

    logic w_rise;
    logic w_fall;

    assign w_rise = level & ~r_prev;
    assign w_fall = ~level & r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev  <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_rel   <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
        end else begin
            r_prev <= level;
            r_rise <= 1'b0;
            r_rel  <= 1'b0;
            r_long <= 1'b0;
            r_rep  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_rise  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A fall beats a coincident tick, so no long-press is
                    // reported for a button let go on the threshold tick.
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_rel   <= 1'b1;
                    end else if (tick) begin
                        if (r_cnt == c_hold_last) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                            r_long  <= 1'b1;
                        end else if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_rel   <= 1'b1;
                    end else if (tick) begin
`ifdef BUTTON_AUTOREPEAT_EN
                        if (r_cnt == c_rep_last) begin
                            r_cnt <= '0;
                            r_rep <= 1'b1;
                        end else if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`else
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // An auto-repeat is presented locally as another press.
    assign press         = r_rise | r_rep;
    assign release_pulse = r_rel;
    assign long_press    = r_long;
    assign rise_ev       = r_rise;
    assign repeat_ev     = r_rep;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_gen
//  Description : Turns a debounced button bus into discrete events. One
//                button_chan_fsm per bit produces press/release/long-press
//                pulses; this level records them as pending flags and
//                serialises them onto a valid/ready event stream.
//  Ports       : clk, reset (sync, active-low)
//                level[NUM_BITS]        debounced levels, 1 = pressed
//                tick                   slow timing strobe
//                press/release_pulse/long_press[NUM_BITS] per-bit pulses
//                ev_valid/ev_ready      event handshake
//                ev_idx, ev_type        event payload
//                ev_overflow            sticky, event lost while pending
//                (the release output is named release_pulse because
//                 "release" is a reserved word in SystemVerilog)
//  Config      : BUTTON_AUTOREPEAT_EN enables EV_REPEAT generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_gen
    import button_event_pkg::*;
#(
    parameter  int NUM_BITS     = 8,
    parameter  int HOLD_TICKS   = 500,
    parameter  int REPEAT_TICKS = 100,
    localparam int CNT_W        = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1),
    localparam int IDX_W        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] level,
    input  logic                tick,
    output logic [NUM_BITS-1:0] press,
    output logic [NUM_BITS-1:0] release_pulse,
    output logic [NUM_BITS-1:0] long_press,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [IDX_W-1:0]    ev_idx,
    output ev_type_t            ev_type,
    output logic                ev_overflow
);

    logic [NUM_BITS-1:0] w_rise;
    logic [NUM_BITS-1:0] w_rep;

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_chan
            button_chan_fsm #(
                .HOLD_TICKS   (HOLD_TICKS),
                .CNT_W        (CNT_W)
`ifdef BUTTON_AUTOREPEAT_EN
                ,
                .REPEAT_TICKS (REPEAT_TICKS)
`endif
            ) u_chan (
                .clk           (clk),
                .reset         (reset),
                .level         (level[gi]),
                .tick          (tick),
                .press         (press[gi]),
                .release_pulse (release_pulse[gi]),
                .long_press    (long_press[gi]),
                .rise_ev       (w_rise[gi]),
                .repeat_ev     (w_rep[gi])
            );
        end
    endgenerate

    // Pending flags, one per (bit, event type). The event currently on the
    // output stays pending until its handshake.
    logic [NUM_BITS-1:0][NUM_EV_TYPES-1:0] r_pend;
    logic [NUM_BITS-1:0][NUM_EV_TYPES-1:0] w_new;
    logic [NUM_BITS-1:0][NUM_EV_TYPES-1:0] w_clr;
    logic [NUM_BITS-1:0][NUM_EV_TYPES-1:0] w_pend_next;

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    ev_type_t         r_type;
    logic             r_ovf;

    logic             w_hs;
    logic             w_lost;
    logic             w_sel_valid;
    logic [IDX_W-1:0] w_sel_idx;
    ev_type_t         w_sel_type;

    assign w_hs = r_valid & ev_ready;

    always_comb begin
        w_new = '0;
        w_clr = '0;
        for (int b = 0; b < NUM_BITS; b++) begin
            w_new[b][EV_PRESS]   = w_rise[b];
            w_new[b][EV_RELEASE] = release_pulse[b];
            w_new[b][EV_LONG]    = long_press[b];
            w_new[b][EV_REPEAT]  = w_rep[b];
            for (int t = 0; t < NUM_EV_TYPES; t++) begin
                w_clr[b][t] = w_hs && (r_idx == IDX_W'(b)) && (r_type == 2'(t));
            end
        end
    end

    // A flag freed by this cycle's handshake can accept a new event; only a
    // flag that remains set causes a drop.
    assign w_pend_next = (r_pend & ~w_clr) | w_new;
    assign w_lost      = |(w_new & r_pend & ~w_clr);

    // Lowest index wins: scanning downwards lets the lowest bit overwrite.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_type  = EV_PRESS;
        for (int b = NUM_BITS - 1; b >= 0; b--) begin
            if (|w_pend_next[b]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(b);
                if (w_pend_next[b][EV_RELEASE]) begin
                    w_sel_type = EV_RELEASE;
                end else if (w_pend_next[b][EV_LONG]) begin
                    w_sel_type = EV_LONG;
                end else if (w_pend_next[b][EV_REPEAT]) begin
                    w_sel_type = EV_REPEAT;
                end else begin
                    w_sel_type = EV_PRESS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_type  <= EV_PRESS;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_lost) begin
                r_ovf <= 1'b1;
            end
            // Output slot reloads only when empty or being consumed.
            if (!r_valid || w_hs) begin
                r_valid <= w_sel_valid;
                r_idx   <= w_sel_idx;
                r_type  <= w_sel_type;
            end
        end
    end

    assign ev_valid    = r_valid;
    assign ev_idx      = r_idx;
    assign ev_type     = r_type;
    assign ev_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_gen
//  Description : Self-checking bench for button_event_gen (NUM_BITS=4,
//                HOLD_TICKS=3, REPEAT_TICKS=2, tick every 4 clocks).
//                Stimulus pushes expected events into a queue; a monitor
//                pops and compares on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;
    import button_event_pkg::*;

    localparam int NB = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          tick     = 1'b0;
    logic          ev_ready = 1'b1;
    logic [NB-1:0] level    = '0;
    logic [NB-1:0] press;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] long_press;
    logic          ev_valid;
    logic [1:0]    ev_idx;
    ev_type_t      ev_type;
    logic          ev_overflow;

    button_event_gen #(
        .NUM_BITS     (NB),
        .HOLD_TICKS   (3),
        .REPEAT_TICKS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .level         (level),
        .tick          (tick),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_idx        (ev_idx),
        .ev_type       (ev_type),
        .ev_overflow   (ev_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic [1:0] typ;
    } ev_t;
    ev_t exp_q[$];

    int press_cnt[NB];
    int rel_cnt[NB];
    int long_cnt[NB];

    bit tick_en    = 1'b0;
    int tphase     = 0;
    int ticks_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input ev_type_t t);
        ev_t e;
        e.idx = 2'(i);
        e.typ = t;
        exp_q.push_back(e);
    endtask

    // Advance one clock; inputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        tick   = tick_en && (tphase == 3);
        tphase = (tphase + 1) % 4;
        if (tick) ticks_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        ev_t e;
        for (int b = 0; b < NB; b++) begin
            if (press[b])         press_cnt[b]++;
            if (release_pulse[b]) rel_cnt[b]++;
            if (long_press[b])    long_cnt[b]++;
        end
        if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got idx %0d type %0d expected none (cycle %0d)",
                         ev_idx, ev_type, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ev_idx", 32'(ev_idx), 32'(e.idx));
                check("ev_type", 32'(ev_type), 32'(e.typ));
            end
        end
    end

    initial begin
        int p0;

        // ---------------- reset state ----------------
        steps(3);
        @(negedge clk);
        check("reset_outputs", {press, release_pulse, long_press, ev_valid, ev_overflow}, 32'd0);
        check("reset_idx_type", {ev_idx, ev_type}, 32'd0);
        step();
        reset = 1'b1;

        // ---------------- press latency on bit 1 ----------------
        while (cyc < 10) step();
        level[1] = 1'b1;
        push(1, EV_PRESS);
        @(negedge clk);
        check("press_not_early", 32'(press), 32'd0);
        step();
        @(negedge clk);
        check("press1_at_11", 32'(press), 32'b0010);
        step();
        @(negedge clk);
        check("ev_valid_at_12", {ev_valid, ev_idx, ev_type}, {1'b1, 2'd1, EV_PRESS});
        step();
        level[1] = 1'b0;
        push(1, EV_RELEASE);
        steps(4);

        // ---------------- long press on bit 2 ----------------
        tick_en = 1'b1;
        level[2] = 1'b1;
        push(2, EV_PRESS);
        ticks_seen = 0;
        while (ticks_seen < 3) begin
            step();
            if (ticks_seen == 2 && tick) check("no_long_before_3", 32'(long_cnt[2]), 32'd0);
        end
        push(2, EV_LONG);
        steps(2);
        check("long2_once", 32'(long_cnt[2]), 32'd1);
        level[2] = 1'b0;
        push(2, EV_RELEASE);
        steps(3);
        check("long2_after_rel", 32'(long_cnt[2]), 32'd1);
        check("rel2_count", 32'(rel_cnt[2]), 32'd1);

        // ---------------- fall coincides with 3rd tick on bit 0 ----------------
        level[0] = 1'b1;
        push(0, EV_PRESS);
        ticks_seen = 0;
        while (ticks_seen < 3) step();
        level[0] = 1'b0;
        push(0, EV_RELEASE);
        steps(3);
        check("long0_suppressed", 32'(long_cnt[0]), 32'd0);
        check("rel0_count", 32'(rel_cnt[0]), 32'd1);

        // ---------------- 9-tick hold on bit 1 ----------------
        level[1] = 1'b1;
        push(1, EV_PRESS);
        p0 = press_cnt[1];
        ticks_seen = 0;
        while (ticks_seen < 9) begin
            step();
            if (tick) begin
                if (ticks_seen == 3) push(1, EV_LONG);
`ifdef BUTTON_AUTOREPEAT_EN
                if (ticks_seen >= 5 && (ticks_seen % 2) == 1) push(1, EV_REPEAT);
`endif
            end
        end
        step();
        level[1] = 1'b0;
        push(1, EV_RELEASE);
        steps(4);
        check("long1_once", 32'(long_cnt[1]), 32'd1);
`ifdef BUTTON_AUTOREPEAT_EN
        check("press1_with_repeats", 32'(press_cnt[1] - p0), 32'd4);
`else
        check("press1_no_repeat", 32'(press_cnt[1] - p0), 32'd1);
`endif

        // ---------------- simultaneous rise on bits 0 and 3 ----------------
        tick_en = 1'b0;
        level[0] = 1'b1;
        level[3] = 1'b1;
        push(0, EV_PRESS);
        push(3, EV_PRESS);
        steps(2);
        @(negedge clk);
        check("arb_first_idx0", {ev_valid, ev_idx, ev_type}, {1'b1, 2'd0, EV_PRESS});
        step();
        @(negedge clk);
        check("arb_next_idx3", {ev_valid, ev_idx, ev_type}, {1'b1, 2'd3, EV_PRESS});
        step();
        level[0] = 1'b0;
        level[3] = 1'b0;
        push(0, EV_RELEASE);
        push(3, EV_RELEASE);
        steps(4);
        check("no_overflow_yet", 32'(ev_overflow), 32'd0);
        check("queue_empty_mid", 32'(exp_q.size()), 32'd0);

        // ---------------- overflow under backpressure on bit 3 ----------------
        ev_ready = 1'b0;
        level[3] = 1'b1;
        push(3, EV_PRESS);
        steps(2);
        level[3] = 1'b0;
        push(3, EV_RELEASE);
        steps(2);
        level[3] = 1'b1;                    // second press: flag still set, dropped
        steps(2);
        @(negedge clk);
        check("overflow_set", 32'(ev_overflow), 32'd1);
        check("held_payload", {ev_valid, ev_idx, ev_type}, {1'b1, 2'd3, EV_PRESS});
        step();
        level[3] = 1'b0;                    // second release also dropped
        steps(2);
        ev_ready = 1'b1;
        steps(4);
        check("overflow_sticky", 32'(ev_overflow), 32'd1);
        check("queue_empty_ovf", 32'(exp_q.size()), 32'd0);

        // ---------------- reset while HELD with a stalled event ----------------
        ev_ready = 1'b0;
        tick_en  = 1'b1;
        level[2] = 1'b1;
        ticks_seen = 0;
        while (ticks_seen < 3) step();
        steps(2);
        @(negedge clk);
        check("pre_reset_valid", 32'(ev_valid), 32'd1);
        step();
        reset   = 1'b0;
        tick_en = 1'b0;
        step();
        @(negedge clk);
        check("mid_reset_outputs", {press, release_pulse, long_press, ev_valid, ev_overflow}, 32'd0);
        step();
        reset    = 1'b1;
        ev_ready = 1'b1;
        push(2, EV_PRESS);
        p0 = press_cnt[2];
        steps(3);
        check("press_after_reset", 32'(press_cnt[2] - p0), 32'd1);
        level[2] = 1'b0;
        push(2, EV_RELEASE);
        steps(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
